// File: rtl/demux18_tdm_if.sv
// -----------------------------------------------------------------------------
// demux18_tdm_if
//  Signal bundle for the demux18_tdm serial-to-channel distributor.
//  Serial input side : din, din_valid, mode, s2/s1/s0, sync
//  Channel outputs   : y (per-channel registers), ch (auto-mode pointer)
//  Frame port        : frame, frame_valid -> / <- frame_ready (valid/ready)
//  Status            : overrun (sticky) / clr_ovr
//  master = the side that produces the serial stream and consumes frames,
//  slave  = the demultiplexer itself.
// -----------------------------------------------------------------------------
interface demux18_tdm_if #(
  parameter int NCH  = 8,
  parameter int SELW = 3
);
  logic            din;
  logic            din_valid;
  logic            mode;
  logic            s2;
  logic            s1;
  logic            s0;
  logic            sync;
  logic [NCH-1:0]  y;
  logic [SELW-1:0] ch;
  logic [NCH-1:0]  frame;
  logic            frame_valid;
  logic            frame_ready;
  logic            overrun;
  logic            clr_ovr;

  modport master (
    output din, din_valid, mode, s2, s1, s0, sync, frame_ready, clr_ovr,
    input  y, ch, frame, frame_valid, overrun
  );

  modport slave (
    input  din, din_valid, mode, s2, s1, s0, sync, frame_ready, clr_ovr,
    output y, ch, frame, frame_valid, overrun
  );
endinterface

// File: rtl/demux18_tdm.sv
// -----------------------------------------------------------------------------
// demux18_tdm
//  Registered 1-to-NCH demultiplexer. A serial bit stream is steered onto NCH
//  channel registers, either by a rotating channel pointer (auto/TDM mode,
//  mode=0) or by the external select {s2,s1,s0} (addressed mode, mode=1).
//  In auto mode every completed NCH-bit frame is offered on a valid/ready
//  port; a frame completing while the previous one is still unconsumed is
//  dropped and flagged on the sticky overrun bit.
//  Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - demux18_tdm_if.slave (stream in, channels/frame/status out)
//  NCH must equal 2**SELW and be at least 2.
// -----------------------------------------------------------------------------
module demux18_tdm #(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input logic          clk,
  input logic          rst_n,
  demux18_tdm_if.slave bus
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [NCH-1:0]  y_q,     y_n;
  logic [SELW-1:0] ch_q,    ch_n;
  logic [NCH-1:0]  frame_q, frame_n;
  logic            fv_q,    fv_n;
  logic            ovr_q,   ovr_n;

  logic [SELW-1:0] sel;
  logic            auto_take;
  logic            frame_done;
  logic            frame_drop;

  assign sel       = {bus.s2, bus.s1, bus.s0};
  assign auto_take = bus.din_valid & ~bus.mode;
  // sync wins over rotation, so a bit arriving with sync never closes a frame.
  assign frame_done = auto_take & ~bus.sync & (ch_q == LAST_CH);
  // The pending frame survives only if it is not being consumed on this edge.
  assign frame_drop = frame_done & fv_q & ~bus.frame_ready;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; without these defaults this block would infer latches.
  always_comb begin
    y_n     = y_q;
    ch_n    = ch_q;
    frame_n = frame_q;
    fv_n    = fv_q;
    ovr_n   = ovr_q;

    // Channel steering.
    if (bus.din_valid) begin
      if (bus.mode)      y_n[sel]  = bus.din;
      else if (bus.sync) y_n[0]    = bus.din;
      else               y_n[ch_q] = bus.din;
    end

    // Channel pointer: natural SELW-bit wrap since NCH == 2**SELW.
    if (bus.sync)     ch_n = auto_take ? SELW'(1) : '0;
    else if (auto_take) ch_n = ch_q + SELW'(1);

    // Output handshake: a new frame may replace one being accepted this edge.
    if (frame_done && !frame_drop) begin
      frame_n           = y_q;
      frame_n[NCH-1]    = bus.din;
      fv_n              = 1'b1;
    end else if (fv_q && bus.frame_ready) begin
      fv_n = 1'b0;
    end

    // Set beats clear on the same edge.
    if (frame_drop)       ovr_n = 1'b1;
    else if (bus.clr_ovr) ovr_n = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      ch_q    <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      y_q     <= y_n;
      ch_q    <= ch_n;
      frame_q <= frame_n;
      fv_q    <= fv_n;
      ovr_q   <= ovr_n;
    end
  end

  assign bus.y           = y_q;
  assign bus.ch          = ch_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.overrun     = ovr_q;

endmodule
